// File: rtl/idu_sb_stage.sv
// idu_sb_stage: pipelined RV64 decode stage.
// Classifies the instruction format, builds the sign-extended immediate and
// reads the GPR file. A per-register busy scoreboard stalls the stage on
// RAW/WAW hazards. The bundle is registered, so latency is one cycle.
// Optional macro IDU_SB_WB_BYPASS_EN: when defined, writeback data is
// forwarded straight into the decode cycle, so a consumer of the retiring
// register issues in the writeback cycle instead of one cycle later.
module idu_sb_stage #(
  parameter int XLEN     = 64,
  parameter int INST_LEN = 32,
  parameter int NR_REG   = 32,
  parameter int REG_SEL  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INST_LEN-1:0] in_inst,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [XLEN-1:0]     out_src1,
  output logic [XLEN-1:0]     out_src2,
  output logic [XLEN-1:0]     out_imm,
  output logic [INST_LEN-1:0] out_inst,
  output logic [REG_SEL-1:0]  out_rd,
  output logic                out_wen,
  output logic [2:0]          out_fmt,
  output logic                out_illegal,
  input  logic                wb_valid,
  input  logic [REG_SEL-1:0]  wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                flush
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_INV = 3'd7;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic [2:0] decode_fmt(input logic [6:0] opc);
    logic [2:0] f;
    case (opc)
      7'b0110011, 7'b0111011:                         f = FMT_R;
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111,
      7'b1110011:                                     f = FMT_I;
      7'b0100011:                                     f = FMT_S;
      7'b1100011:                                     f = FMT_B;
      7'b0110111, 7'b0010111:                         f = FMT_U;
      7'b1101111:                                     f = FMT_J;
      default:                                        f = FMT_INV;
    endcase
    return f;
  endfunction

  function automatic logic signed [XLEN-1:0] build_imm(input logic [INST_LEN-1:0] inst,
                                                       input logic [2:0]          fmt);
    logic signed [XLEN-1:0] imm;
    case (fmt)
      FMT_I:   imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
      FMT_S:   imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
      FMT_J:   imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  logic [XLEN-1:0]        regs [NR_REG];
  logic [NR_REG-1:0]      busy;
  logic [NR_REG-1:0]      busy_nxt;

  logic                   vld_p1;
  logic [XLEN-1:0]        pc_p1;
  logic [XLEN-1:0]        src1_p1;
  logic [XLEN-1:0]        src2_p1;
  logic signed [XLEN-1:0] imm_p1;
  logic [INST_LEN-1:0]    inst_p1;
  logic [REG_SEL-1:0]     rd_p1;
  logic                   wen_p1;
  logic [2:0]             fmt_p1;
  logic                   illegal_p1;

  // ---- p0: decode, regfile read, hazard check ----
  logic [6:0]             opc_p0;
  logic [2:0]             fmt_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic [REG_SEL-1:0]     rd_p0, rs1_p0, rs2_p0;
  logic                   use1_p0, use2_p0, wen_p0;
  logic                   byp1_p0, byp2_p0;
  logic                   hazard_p0, accept_p0;
  logic [XLEN-1:0]        src1_p0, src2_p0;

  assign opc_p0  = in_inst[6:0];
  assign fmt_p0  = decode_fmt(opc_p0);
  assign imm_p0  = build_imm(in_inst, fmt_p0);
  assign rd_p0   = in_inst[7 +: REG_SEL];
  assign rs1_p0  = in_inst[15 +: REG_SEL];
  assign rs2_p0  = in_inst[20 +: REG_SEL];
  assign use1_p0 = (fmt_p0 == FMT_R) || (fmt_p0 == FMT_I) ||
                   (fmt_p0 == FMT_S) || (fmt_p0 == FMT_B);
  assign use2_p0 = (fmt_p0 == FMT_R) || (fmt_p0 == FMT_S) || (fmt_p0 == FMT_B);
  assign wen_p0  = ((fmt_p0 == FMT_R) || (fmt_p0 == FMT_U) || (fmt_p0 == FMT_J) ||
                    ((fmt_p0 == FMT_I) && (opc_p0 != OPC_SYSTEM))) && (rd_p0 != '0);

`ifdef IDU_SB_WB_BYPASS_EN
  assign byp1_p0 = wb_valid && (wb_rd == rs1_p0) && (rs1_p0 != '0);
  assign byp2_p0 = wb_valid && (wb_rd == rs2_p0) && (rs2_p0 != '0);
`else
  assign byp1_p0 = 1'b0;
  assign byp2_p0 = 1'b0;
`endif

  // x0 is never busy and regs[0] is never written, so index 0 reads 0 here.
  assign src1_p0 = !use1_p0 ? '0 : (byp1_p0 ? wb_data : regs[rs1_p0]);
  assign src2_p0 = !use2_p0 ? '0 : (byp2_p0 ? wb_data : regs[rs2_p0]);

  assign hazard_p0 = (use1_p0 && busy[rs1_p0] && !byp1_p0) ||
                     (use2_p0 && busy[rs2_p0] && !byp2_p0) ||
                     (wen_p0 && busy[rd_p0]);
  assign in_ready  = (!vld_p1 || out_ready) && !hazard_p0 && !flush;
  assign accept_p0 = in_valid && in_ready;

  // Next scoreboard: writeback clears, a new accept sets; set wins on a tie.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid && (wb_rd != '0)) busy_nxt[wb_rd] = 1'b0;
    if (accept_p0 && wen_p0)       busy_nxt[rd_p0] = 1'b1;
  end

  // Scoreboard register; flush discards every outstanding destination.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       busy <= '0;
    else if (flush) busy <= '0;
    else            busy <= busy_nxt;
  end

  // GPR file; writes to x0 are dropped, and flush does not block writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NR_REG; i++) regs[i] <= '0;
    end else if (wb_valid && (wb_rd != '0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // ---- p1: registered bundle towards EXU ----
  // Bundle valid: set on accept, dropped on transfer or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           vld_p1 <= 1'b0;
    else if (flush)     vld_p1 <= 1'b0;
    else if (accept_p0) vld_p1 <= 1'b1;
    else if (out_ready) vld_p1 <= 1'b0;
  end

  // Bundle payload: loads only on accept, so it holds while EXU back-pressures.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_p1      <= '0;
      src1_p1    <= '0;
      src2_p1    <= '0;
      imm_p1     <= '0;
      inst_p1    <= '0;
      rd_p1      <= '0;
      wen_p1     <= 1'b0;
      fmt_p1     <= 3'd0;
      illegal_p1 <= 1'b0;
    end else if (accept_p0) begin
      pc_p1      <= in_pc;
      src1_p1    <= src1_p0;
      src2_p1    <= src2_p0;
      imm_p1     <= imm_p0;
      inst_p1    <= in_inst;
      rd_p1      <= rd_p0;
      wen_p1     <= wen_p0;
      fmt_p1     <= fmt_p0;
      illegal_p1 <= (fmt_p0 == FMT_INV);
    end
  end

  assign out_valid   = vld_p1;
  assign out_pc      = pc_p1;
  assign out_src1    = src1_p1;
  assign out_src2    = src2_p1;
  assign out_imm     = imm_p1;
  assign out_inst    = inst_p1;
  assign out_rd      = rd_p1;
  assign out_wen     = wen_p1;
  assign out_fmt     = fmt_p1;
  assign out_illegal = illegal_p1;

endmodule

// File: tb/tb_idu_sb_stage.sv
// Testbench for idu_sb_stage: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of the decode rules,
// scoreboard and handshake kept in this file.
module tb_idu_sb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [63:0] out_src1;
  logic [63:0] out_src2;
  logic [63:0] out_imm;
  logic [31:0] out_inst;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [2:0]  out_fmt;
  logic        out_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        flush;

  always #5 clk = ~clk;

  idu_sb_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_src1(out_src1), .out_src2(out_src2), .out_imm(out_imm),
    .out_inst(out_inst), .out_rd(out_rd), .out_wen(out_wen),
    .out_fmt(out_fmt), .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush)
  );

  localparam logic [31:0] ADDI_X1_5   = 32'h00500093;
  localparam logic [31:0] ADD_X2_X1   = 32'h00108133;
  localparam logic [31:0] ADDI_X6_7   = 32'h00700313;
  localparam logic [31:0] ADDI_X10_1  = 32'h00100513;
  localparam logic [31:0] ADDI_X11_1  = 32'h00100593;
  localparam logic [31:0] ADDI_X12_1  = 32'h00100613;
  localparam logic [31:0] JAL_X1_M4   = 32'hFFDFF0EF;
  localparam logic [31:0] LUI_X3      = 32'h800001B7;
  localparam logic [31:0] LUI_X4      = 32'h00001237;
  localparam logic [31:0] ADDI_X5_X4  = 32'h00120293;
  localparam logic [31:0] BAD_OPC     = 32'h00000FFF;
  localparam logic [31:0] ADD_X14_X0  = 32'h00000733;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference state
  logic [63:0] m_regs [32];
  bit          m_busy [32];
  bit          m_vld;
  logic [63:0] m_pc, m_s1, m_s2, m_imm;
  logic [31:0] m_inst;
  logic [4:0]  m_rd;
  bit          m_wen;
  logic [2:0]  m_fmt;
  bit          ready_seen;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_vld = 1'b0;
  endtask

  function automatic logic [2:0] ref_fmt(input logic [6:0] op);
    case (op)
      7'h33, 7'h3B:                      return 3'd0;
      7'h13, 7'h1B, 7'h03, 7'h67, 7'h73: return 3'd1;
      7'h23:                             return 3'd2;
      7'h63:                             return 3'd3;
      7'h37, 7'h17:                      return 3'd4;
      7'h6F:                             return 3'd5;
      default:                           return 3'd7;
    endcase
  endfunction

  // Immediate value as a plain integer: weight each field, then wrap negative.
  function automatic longint ref_imm(input logic [31:0] i, input logic [2:0] f);
    longint v;
    case (f)
      3'd1: begin
        v = longint'(i[31:20]);
        if (v >= 2048) v -= 4096;
      end
      3'd2: begin
        v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
        if (v >= 2048) v -= 4096;
      end
      3'd3: begin
        v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
            longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      3'd4: begin
        v = longint'(i[31:12]) * 4096;
        if (v >= 64'sd2147483648) v -= 64'sd4294967296;
      end
      3'd5: begin
        v = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 +
            longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  // One clock cycle: entered 1 time unit after a rising edge with inputs driven.
  task automatic step();
    logic [2:0]  f;
    logic [4:0]  rd, rs1, rs2;
    bit          use1, use2, wen, byp1, byp2, haz, exp_rdy, acc;
    logic [63:0] s1, s2;
    #1;
    f    = ref_fmt(in_inst[6:0]);
    rd   = in_inst[11:7];
    rs1  = in_inst[19:15];
    rs2  = in_inst[24:20];
    use1 = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd3);
    use2 = (f == 3'd0) || (f == 3'd2) || (f == 3'd3);
    wen  = ((f == 3'd0) || (f == 3'd4) || (f == 3'd5) ||
            ((f == 3'd1) && (in_inst[6:0] != 7'h73))) && (rd != 0);
`ifdef IDU_SB_WB_BYPASS_EN
    byp1 = wb_valid && (wb_rd == rs1) && (rs1 != 0);
    byp2 = wb_valid && (wb_rd == rs2) && (rs2 != 0);
`else
    byp1 = 1'b0;
    byp2 = 1'b0;
`endif
    haz = (use1 && m_busy[rs1] && !byp1) || (use2 && m_busy[rs2] && !byp2) ||
          (wen && m_busy[rd]);
    exp_rdy = (!m_vld || out_ready) && !haz && !flush;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    ready_seen = in_ready;
    acc = in_valid && exp_rdy;
    s1 = !use1 ? 64'd0 : (byp1 ? wb_data : m_regs[rs1]);
    s2 = !use2 ? 64'd0 : (byp2 ? wb_data : m_regs[rs2]);

    if (wb_valid && wb_rd != 0) m_regs[wb_rd] = wb_data;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (wb_valid && wb_rd != 0) m_busy[wb_rd] = 1'b0;
      if (acc && wen) m_busy[rd] = 1'b1;
    end
    if (flush) m_vld = 1'b0;
    else if (acc) begin
      m_vld  = 1'b1;
      m_pc   = in_pc;
      m_s1   = s1;
      m_s2   = s2;
      m_imm  = 64'(ref_imm(in_inst, f));
      m_inst = in_inst;
      m_rd   = rd;
      m_wen  = wen;
      m_fmt  = f;
    end else if (out_ready) m_vld = 1'b0;

    @(posedge clk);
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_vld));
    if (m_vld) begin
      chk("out_pc",      out_pc,   m_pc);
      chk("out_src1",    out_src1, m_s1);
      chk("out_src2",    out_src2, m_s2);
      chk("out_imm",     out_imm,  m_imm);
      chk("out_inst",    64'(out_inst), 64'(m_inst));
      chk("out_rd",      64'(out_rd),   64'(m_rd));
      chk("out_wen",     64'(out_wen),  64'(m_wen));
      chk("out_fmt",     64'(out_fmt),  64'(m_fmt));
      chk("out_illegal", 64'(out_illegal), 64'(m_fmt == 3'd7));
    end
  endtask

  task automatic cyc(input bit v, input logic [31:0] ins, input bit ordy,
                     input bit wbv, input logic [4:0] wrd, input logic [63:0] wd,
                     input bit fl);
    in_valid  = v;
    in_inst   = ins;
    in_pc     = {$urandom, $urandom};
    out_ready = ordy;
    wb_valid  = wbv;
    wb_rd     = wrd;
    wb_data   = wd;
    flush     = fl;
    step();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [16] = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h73, 7'h23,
                              7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h00, 7'h0B, 7'h13};
    logic [31:0] ins;
    ins        = $urandom;
    ins[6:0]   = ops[$urandom_range(0, 15)];
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc",    out_pc,   64'd0);
    chk("rst_out_src1",  out_src1, 64'd0);
    chk("rst_out_imm",   out_imm,  64'd0);
    chk("rst_out_fmt",   64'(out_fmt), 64'd0);
    chk("rst_in_ready",  64'(in_ready), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // addi x1,x0,5 issues with one cycle latency
    cyc(1, ADDI_X1_5, 1, 0, 0, 0, 0);
    chk("addi_vld",  64'(out_valid), 64'd1);
    chk("addi_fmt",  64'(out_fmt),   64'd1);
    chk("addi_imm",  out_imm,        64'd5);
    chk("addi_src1", out_src1,       64'd0);
    chk("addi_rd",   64'(out_rd),    64'd1);
    chk("addi_wen",  64'(out_wen),   64'd1);

    // RAW on x1 stalls until writeback
    cyc(1, ADD_X2_X1, 1, 0, 0, 0, 0);
    chk("raw_stall", 64'(ready_seen), 64'd0);
    cyc(1, ADD_X2_X1, 1, 1, 5'd1, 64'd5, 0);
`ifdef IDU_SB_WB_BYPASS_EN
    chk("byp_accept", 64'(ready_seen), 64'd1);
`else
    chk("nobyp_stall", 64'(ready_seen), 64'd0);
    cyc(1, ADD_X2_X1, 1, 0, 0, 0, 0);
    chk("nobyp_accept", 64'(ready_seen), 64'd1);
`endif
    chk("raw_src1", out_src1, 64'd5);
    chk("raw_src2", out_src2, 64'd5);

    // Back-pressure holds the bundle, then back-to-back issue
    for (int k = 0; k < 3; k++) begin
      cyc(1, ADDI_X6_7, 0, 0, 0, 0, 0);
      chk("bp_ready", 64'(ready_seen), 64'd0);
      chk("bp_hold",  64'(out_inst), 64'(ADD_X2_X1));
    end
    cyc(1, ADDI_X6_7, 1, 0, 0, 0, 0);
    chk("bp_release", 64'(ready_seen), 64'd1);
    cyc(1, ADDI_X10_1, 1, 0, 0, 0, 0);
    chk("b2b_0", 64'(ready_seen), 64'd1);
    cyc(1, ADDI_X11_1, 1, 0, 0, 0, 0);
    chk("b2b_1", 64'(ready_seen), 64'd1);
    cyc(1, ADDI_X12_1, 1, 0, 0, 0, 0);
    chk("b2b_2", 64'(ready_seen), 64'd1);
    chk("b2b_inst", 64'(out_inst), 64'(ADDI_X12_1));

    // Immediates
    cyc(1, JAL_X1_M4, 1, 0, 0, 0, 0);
    chk("jal_fmt", 64'(out_fmt), 64'd5);
    chk("jal_imm", out_imm, 64'hFFFFFFFFFFFFFFFC);
    cyc(1, LUI_X3, 1, 0, 0, 0, 0);
    chk("lui_imm", out_imm, 64'hFFFFFFFF80000000);

    // Flush kills pending bundle and scoreboard
    cyc(1, LUI_X4, 1, 0, 0, 0, 0);
    cyc(0, 32'h0, 0, 0, 0, 0, 1);
    chk("flush_vld", 64'(out_valid), 64'd0);
    cyc(1, ADDI_X5_X4, 1, 0, 0, 0, 0);
    chk("flush_dep_ready", 64'(ready_seen), 64'd1);

    // Unknown opcode
    cyc(1, BAD_OPC, 1, 0, 0, 0, 0);
    chk("inv_fmt", 64'(out_fmt), 64'd7);
    chk("inv_illegal", 64'(out_illegal), 64'd1);
    chk("inv_wen", 64'(out_wen), 64'd0);

    // Writeback to x0 is dropped
    cyc(0, 32'h0, 1, 1, 5'd0, 64'hDEAD, 0);
    cyc(1, ADD_X14_X0, 1, 0, 0, 0, 0);
    chk("x0_src1", out_src1, 64'd0);
    chk("x0_src2", out_src2, 64'd0);

    // Asynchronous reset while stalled
    cyc(1, ADDI_X10_1, 1, 0, 0, 0, 0);
    cyc(1, ADDI_X11_1, 0, 0, 0, 0, 0);
    chk("pre_rst_stall", 64'(ready_seen), 64'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_async_vld", 64'(out_valid), 64'd0);
    chk("rst_async_pc",  out_pc, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int          busy_q [$];
      logic [4:0]  wrd;
      for (int r = 1; r < 8; r++) if (m_busy[r]) busy_q.push_back(r);
      if (busy_q.size() > 0 && $urandom_range(0, 3) != 0)
        wrd = 5'(busy_q[$urandom_range(0, busy_q.size() - 1)]);
      else
        wrd = 5'($urandom_range(0, 7));
      cyc($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0, wrd, {$urandom, $urandom},
          $urandom_range(0, 31) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/idu_sb_stage.md
Name: idu_sb_stage

Overview:
- Pipelined RV64 decode stage: classifies the instruction format, builds the immediate, and reads the register file.
- Holds a per-register busy scoreboard and stalls on RAW/WAW hazards.
- Sits between IFU and EXU with valid/ready handshakes on both sides; writeback from the LSU/WBU enters via a dedicated port.
- Successor to the single-cycle IDU: adds pipelining, hazard tracking, writeback forwarding and a configurable register count.

Parameters:
XLEN, 64, datapath width
INST_LEN, 32, instruction width
NR_REG, 32, number of GPRs (x0 hardwired 0)
REG_SEL, 5, register index width, equals clog2(NR_REG)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
in_valid  in  1  IFU has an instruction
in_ready  out  1  stage accepts this cycle
in_inst  in  INST_LEN  instruction
in_pc  in  XLEN  instruction PC
out_valid  out  1  decoded bundle valid
out_ready  in  1  EXU accepts bundle
out_pc  out  XLEN  registered PC
out_src1  out  XLEN  rs1 value, 0 if unused
out_src2  out  XLEN  rs2 value, 0 if unused
out_imm  out  XLEN  sign-extended immediate
out_inst  out  INST_LEN  raw instruction for EXU op decode
out_rd  out  REG_SEL  destination index
out_wen  out  1  bundle writes rd
out_fmt  out  3  0=R 1=I 2=S 3=B 4=U 5=J 7=INV
out_illegal  out  1  unknown opcode
wb_valid  in  1  writeback strobe
wb_rd  in  REG_SEL  writeback index
wb_data  in  XLEN  writeback data
flush  in  1  kill in-flight bundle and scoreboard

Behaviour:
- Reset (rst=0, async): out_valid=0; all out_* data 0; busy[] all 0; all GPRs 0.
- Format by opcode:
  - R: 0110011, 0111011.
  - I: 0010011, 0011011, 0000011, 1100111, 1110011.
  - S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111.
  - Any other opcode: INV with out_illegal=1.
- Immediate, sign-extended to XLEN:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R and INV: 0.
- Source use:
  - R/S/B use rs1 and rs2; I uses rs1 only; U/J/INV use neither.
  - Unused sources output 0.
  - Index 0 always reads 0 and is never busy.
- Write enable:
  - wen=1 for R, I (except opcode 1110011), U, J.
  - wen=0 when rd=0.
- Hazard (combinational): any of the following stalls the instruction.
  - A used source with busy[rs]=1, unless bypassed (see Optional Feature).
  - wen=1 with busy[rd]=1 (WAW).
- Handshake:
  - in_ready = (!out_valid | out_ready) & !hazard & !flush.
  - Accept = in_valid & in_ready; the bundle is registered next edge, so latency is 1 cycle.
  - Bundle holds stable while out_valid & !out_ready.
  - out_valid drops after a transfer unless a new accept occurs the same cycle; back-to-back throughput is 1/cycle.
- Scoreboard:
  - On accept with wen, busy[rd] is set.
  - On wb_valid with wb_rd!=0, regs[wb_rd] is written and busy[wb_rd] is cleared.
  - If set and clear target the same index in one cycle, set wins.
- Writeback to x0 is ignored.
- flush: next edge out_valid=0 and busy[] all 0; no accept that cycle. A wb in the same cycle still writes the GPR.
- Reset mid-stall drops the pending bundle immediately.

Optional Feature:
Macro: IDU_SB_WB_BYPASS_EN
- Defined:
  - A source whose busy bit is being cleared by wb_valid/wb_rd this cycle takes wb_data directly.
  - That source does not stall, so the consumer issues in the writeback cycle.
- Undefined:
  - No forwarding; the source stalls until busy clears.
  - The instruction reads the regfile the cycle after writeback (one extra stall cycle).

Test Plan:
- Reset, then issue addi x1,x0,5 (0x00500093) with out_ready=1 -> next cycle out_valid=1, out_fmt=1, out_imm=5, out_src1=0, out_rd=1, out_wen=1; busy[1]=1.
- With x1 busy, issue add x2,x1,x1 -> in_ready=0 stall. Then wb_valid, wb_rd=1, wb_data=0x5:
  - with bypass: accepted that cycle, out_src1=out_src2=5 next cycle.
  - without bypass: accepted one cycle later.
- Hold out_ready=0 for 3 cycles with a valid bundle -> bundle stays stable, in_ready=0. Release -> transfer, then back-to-back accepts at 1/cycle.
- Immediate checks:
  - jal inst 0xFFDFF0EF -> out_fmt=5, out_imm=0xFFFFFFFFFFFFFFFC.
  - lui x3,0x80000 -> out_imm=0xFFFFFFFF80000000.
- Issue lui x4, then flush while its bundle is pending -> out_valid=0 and busy[4]=0 next cycle. A dependent addi x5,x4,1 is then accepted without stall.
- Edge cases:
  - opcode 0x7F -> out_fmt=7, out_illegal=1, out_wen=0.
  - wb_rd=0 with wb_data=0xDEAD -> x0 still reads 0.
  - rst pulsed low mid-stall -> out_valid=0 immediately.
